// File: rtl/gfx_pattern_ahb_master.sv
// gfx_pattern_ahb_master: AHB-Lite master that fills a framebuffer with vertical colour bars, then enables scan-out.
// Ports:
//   hclk, hresetn       clock, synchronous active-low reset
//   start               1-cycle pulse, starts a fill from IDLE/DONE/ERROR
//   haddr_m .. hwdata_m AHB-Lite master outputs (NONSEQ single word writes only)
//   hready_m, hresp_m   AHB-Lite slave responses
//   busy, done, error   sequence status; done/error are sticky until the next start
module gfx_pattern_ahb_master #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          BAR_COUNT  = 8,
    parameter logic [31:0] CTRL_ADDR  = 32'h8000_0000,
    parameter logic [31:0] CTRL_VALUE = 32'h0000_0001
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        start,
    output logic [31:0] haddr_m,
    output logic [1:0]  htrans_m,
    output logic        hwrite_m,
    output logic [2:0]  hsize_m,
    output logic [2:0]  hburst_m,
    output logic [31:0] hwdata_m,
    input  logic        hready_m,
    input  logic        hresp_m,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int XW = H_RES / 2;
    localparam int BW = H_RES / (2 * BAR_COUNT);
    localparam int XB = $clog2(XW + 1);
    localparam int YB = $clog2(V_RES + 1);
    localparam int BB = $clog2(BW + 1);
    localparam logic [XB-1:0] X_LAST = XB'(XW - 1);
    localparam logic [YB-1:0] Y_LAST = YB'(V_RES - 1);
    localparam logic [BB-1:0] B_LAST = BB'(BW - 1);
    localparam logic [15:0] COLOURS [8] = '{16'hFFFF, 16'hFFC0, 16'h07FF, 16'h07C0,
                                            16'hF83F, 16'hF800, 16'h003F, 16'h0000};

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CTRL, S_DRAIN, S_DONE, S_ERROR} state_t;

    state_t         state_q, state_d;
    logic [31:0]    haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic           act_q, act_d, dp_q, dp_d;
    logic [XB-1:0]  x_q, x_d;
    logic [YB-1:0]  y_q, y_d;
    logic [BB-1:0]  bcnt_q, bcnt_d;
    logic [2:0]     bar_q, bar_d;
    logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic           acc, x_wrap, b_wrap, last_word, go;
    logic [15:0]    col;

    always_comb begin
        acc       = act_q & hready_m;
        x_wrap    = x_q == X_LAST;
        b_wrap    = bcnt_q == B_LAST;
        last_word = x_wrap & (y_q == Y_LAST);
        col       = COLOURS[bar_q];
        go        = start & ~busy_q;
        state_d   = state_q;
        haddr_d   = haddr_q;
        act_d     = act_q;
        x_d       = x_q;
        y_d       = y_q;
        bcnt_d    = bcnt_q;
        bar_d     = bar_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        // a data phase starts on every accepted address and ends on the first ready cycle
        dp_d      = acc ? 1'b1 : (hready_m ? 1'b0 : dp_q);
        hwdata_d  = acc ? (state_q == S_CTRL ? CTRL_VALUE : {col, col}) : hwdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (go) begin
                state_d = S_FILL;
                act_d   = 1'b1;
                haddr_d = FB_BASE;
                x_d     = '0;
                y_d     = '0;
                bcnt_d  = '0;
                bar_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                error_d = 1'b0;
            end
            S_FILL: if (acc) begin
                if (last_word) begin
                    state_d = S_CTRL;
                    haddr_d = CTRL_ADDR;
                end else begin
                    haddr_d = haddr_q + 32'd4;
                    x_d     = x_wrap ? '0 : x_q + XB'(1);
                    y_d     = x_wrap ? y_q + YB'(1) : y_q;
                    bcnt_d  = b_wrap ? '0 : bcnt_q + BB'(1);
                    // bar width is an even pixel count, so both pixels of a word share a bar
                    bar_d   = x_wrap ? 3'd0 : (b_wrap ? bar_q + 3'd1 : bar_q);
                end
            end
            S_CTRL: if (acc) begin
                state_d = S_DRAIN;
                act_d   = 1'b0;
            end
            S_DRAIN: if (dp_q & hready_m & ~hresp_m) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: ;
        endcase
        // first ERROR cycle withdraws the pipelined address; the flag lands when the response completes
        if (dp_q & hresp_m) begin
            state_d = S_ERROR;
            act_d   = 1'b0;
            if (hready_m) begin
                busy_d  = 1'b0;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwdata_q <= '0;
            act_q    <= 1'b0;
            dp_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            bcnt_q   <= '0;
            bar_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            act_q    <= act_d;
            dp_q     <= dp_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bcnt_q   <= bcnt_d;
            bar_q    <= bar_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign haddr_m  = haddr_q;
    assign htrans_m = act_q ? 2'b10 : 2'b00;
    assign hwrite_m = act_q;
    assign hsize_m  = 3'b010;
    assign hburst_m = 3'b000;
    assign hwdata_m = hwdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
endmodule
